// File: rtl/memoria_programa_carregavel_if.sv
// -----------------------------------------------------------------------------
// memoria_programa_carregavel_if
//
// Bundles the fetch port and the streaming loader port of the loadable program
// memory, so the fetch stage / boot loader and the memory share one connection.
//
// Signals:
//   fetch_req, fetch_addr      : read request and address (master -> slave)
//   q, q_valid                 : registered read data and its one-cycle strobe
//   busy                       : memory is loading or clearing, fetches ignored
//   load_start                 : begin a new program load
//   load_data, load_valid,
//   load_last, load_ready      : valid/ready word stream, last word qualified
//   load_count                 : words accepted by the current/last load
//   load_done                  : one-cycle pulse on return to normal operation
//   load_error                 : sticky overflow flag
//
// Modports: master = fetch stage / host, slave = the program memory.
// -----------------------------------------------------------------------------
interface memoria_programa_carregavel_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;
    logic                  load_start;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_valid;
    logic                  load_last;
    logic                  load_ready;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_done;
    logic                  load_error;

    modport master (
        output fetch_req, fetch_addr, load_start, load_data, load_valid, load_last,
        input  q, q_valid, busy, load_ready, load_count, load_done, load_error
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_data, load_valid, load_last,
        output q, q_valid, busy, load_ready, load_count, load_done, load_error
    );
endinterface

// File: rtl/memoria_programa_carregavel.sv
// -----------------------------------------------------------------------------
// memoria_programa_carregavel
//
// Program memory for the stack CPU with a built-in streaming loader.
// In RUN it serves one registered fetch per cycle. On load_start it accepts a
// new program as a valid/ready stream written from address 0, and (when
// CLEAR_TAIL=1) zero-fills every address after the last loaded word so no
// stale instructions survive.
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; returns to RUN, RAM contents untouched
//   bus   : slave side of memoria_programa_carregavel_if (fetch + loader)
//
// Parameters:
//   DATA_WIDTH : instruction word width
//   ADDR_WIDTH : address width, DEPTH = 2**ADDR_WIDTH
//   CLEAR_TAIL : 1 = zero-fill after the last loaded word, 0 = leave it
// -----------------------------------------------------------------------------
module memoria_programa_carregavel #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter bit CLEAR_TAIL = 1'b1
) (
    input logic                         clock,
    input logic                         reset,
    memoria_programa_carregavel_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  q_valid_q, q_valid_d;
    logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram [DEPTH];

    // Next-state and datapath decisions for the RUN/LOAD/CLEAR controller.
    // Writes always go to wp_q; the write data is the streamed word in LOAD
    // and zero in CLEAR.
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        q_d          = q_q;
        q_valid_d    = 1'b0;
        load_count_d = load_count_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        ram_we       = 1'b0;
        ram_wdata    = bus.load_data;

        case (state_q)
            RUN: begin
                if (bus.fetch_req) begin
                    q_d       = ram[bus.fetch_addr];
                    q_valid_d = 1'b1;
                end
                if (bus.load_start) begin
                    state_d      = LOAD;
                    wp_d         = '0;
                    load_count_d = '0;
                    load_error_d = 1'b0;
                end
            end

            LOAD: begin
                if (bus.load_valid) begin
                    ram_we       = 1'b1;
                    load_count_d = load_count_q + COUNT_ONE;
                    // The pointer stops at the top address so a full memory
                    // never wraps back onto word 0.
                    if (wp_q != LAST_ADDR) begin
                        wp_d = wp_q + ADDR_ONE;
                    end
                    if (bus.load_last) begin
                        if (CLEAR_TAIL && (wp_q != LAST_ADDR)) begin
                            state_d = CLEAR;
                        end else begin
                            state_d     = RUN;
                            load_done_d = 1'b1;
                        end
                    end else if (wp_q == LAST_ADDR) begin
                        load_error_d = 1'b1;
                        state_d      = RUN;
                        load_done_d  = 1'b1;
                    end
                end
            end

            CLEAR: begin
                ram_we    = 1'b1;
                ram_wdata = '0;
                if (wp_q == LAST_ADDR) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end else begin
                    wp_d = wp_q + ADDR_ONE;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // A reset cycle aborts the load without touching memory.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Control and output registers, synchronously reset to the idle RUN state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RUN;
            wp_q         <= '0;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            load_count_q <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            load_count_q <= load_count_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    // Storage array: no reset, so a reset mid-load keeps the words written.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[wp_q] <= ram_wdata;
        end
    end

    assign bus.q          = q_q;
    assign bus.q_valid    = q_valid_q;
    assign bus.busy       = (state_q != RUN);
    assign bus.load_ready = (state_q == LOAD);
    assign bus.load_count = load_count_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_memoria_programa_carregavel.sv
// -----------------------------------------------------------------------------
// tb_memoria_programa_carregavel
//
// Drives two instances (CLEAR_TAIL=1 "clr" and CLEAR_TAIL=0 "keep") with the
// same stimulus and compares both against simple per-instance memory models.
// -----------------------------------------------------------------------------
module tb_memoria_programa_carregavel;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          load_start = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_last = 1'b0;

    memoria_programa_carregavel_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_clr ();
    memoria_programa_carregavel_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_keep ();

    assign bus_clr.fetch_req   = fetch_req;
    assign bus_clr.fetch_addr  = fetch_addr;
    assign bus_clr.load_start  = load_start;
    assign bus_clr.load_data   = load_data;
    assign bus_clr.load_valid  = load_valid;
    assign bus_clr.load_last   = load_last;
    assign bus_keep.fetch_req  = fetch_req;
    assign bus_keep.fetch_addr = fetch_addr;
    assign bus_keep.load_start = load_start;
    assign bus_keep.load_data  = load_data;
    assign bus_keep.load_valid = load_valid;
    assign bus_keep.load_last  = load_last;

    memoria_programa_carregavel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_TAIL(1'b1)) dut_clr (
        .clock (clock),
        .reset (reset),
        .bus   (bus_clr)
    );

    memoria_programa_carregavel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_TAIL(1'b0)) dut_keep (
        .clock (clock),
        .reset (reset),
        .bus   (bus_keep)
    );

    always #5 clock = ~clock;

    // Reference state: expected memory image and last fetched word per instance.
    logic [DW-1:0] mem_clr  [DEPTH];
    logic [DW-1:0] mem_keep [DEPTH];
    logic [DW-1:0] q_exp_clr;
    logic [DW-1:0] q_exp_keep;
    logic [DW-1:0] words [DEPTH+1];
    int errors = 0;
    int checks = 0;

    // Advance one cycle; outputs are sampled and inputs changed 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fetch on both instances, checked against the model memories.
    task automatic do_fetch(input int addr);
        fetch_req  = 1'b1;
        fetch_addr = AW'(addr);
        tick();
        fetch_req  = 1'b0;
        q_exp_clr  = mem_clr[addr];
        q_exp_keep = mem_keep[addr];
        check_output($sformatf("fetch_valid_clr[%0d]", addr), 32'(bus_clr.q_valid), 32'd1);
        check_output($sformatf("fetch_q_clr[%0d]", addr), 32'(bus_clr.q), 32'(q_exp_clr));
        check_output($sformatf("fetch_valid_keep[%0d]", addr), 32'(bus_keep.q_valid), 32'd1);
        check_output($sformatf("fetch_q_keep[%0d]", addr), 32'(bus_keep.q), 32'(q_exp_keep));
    endtask

    // Full load of words[0..n-1]: start (with a concurrent fetch), stream with
    // optional random gaps, then follow the return to RUN on both instances.
    task automatic apply_stimulus(input int n, input bit has_last, input bit gaps);
        int fa;
        int a;
        int clear_len;
        int first_done;
        int busy_cnt;
        int kmax;
        int g;

        fa         = int'($urandom_range(0, DEPTH - 1));
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = AW'(fa);
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        q_exp_clr  = mem_clr[fa];
        q_exp_keep = mem_keep[fa];
        check_output("start_fetch_valid_clr", 32'(bus_clr.q_valid), 32'd1);
        check_output("start_fetch_q_clr", 32'(bus_clr.q), 32'(q_exp_clr));
        check_output("start_fetch_q_keep", 32'(bus_keep.q), 32'(q_exp_keep));
        check_output("start_ready_clr", 32'(bus_clr.load_ready), 32'd1);
        check_output("start_busy_keep", 32'(bus_keep.busy), 32'd1);
        check_output("start_count_clr", 32'(bus_clr.load_count), 32'd0);
        check_output("start_error_clr", 32'(bus_clr.load_error), 32'd0);

        for (int i = 0; i < n; i++) begin
            g = 0;
            while (gaps && (g < 3) && ($urandom_range(0, 1) == 1)) begin
                load_valid = 1'b0;
                load_data  = DW'($urandom);
                fetch_req  = 1'b1;
                fetch_addr = AW'($urandom_range(0, DEPTH - 1));
                tick();
                fetch_req = 1'b0;
                check_output("busy_fetch_valid_clr", 32'(bus_clr.q_valid), 32'd0);
                check_output("busy_fetch_q_clr", 32'(bus_clr.q), 32'(q_exp_clr));
                check_output("busy_fetch_valid_keep", 32'(bus_keep.q_valid), 32'd0);
                check_output("busy_fetch_q_keep", 32'(bus_keep.q), 32'(q_exp_keep));
                g++;
            end
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = has_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;

        // Model: words land at 0..n-1; the clearing instance zeroes the rest.
        a = n - 1;
        for (int i = 0; i < n; i++) begin
            mem_clr[i]  = words[i];
            mem_keep[i] = words[i];
        end
        if (has_last) begin
            for (int i = n; i < DEPTH; i++) mem_clr[i] = '0;
        end
        clear_len = has_last ? (DEPTH - 1 - a) : 0;

        check_output("end_done_keep", 32'(bus_keep.load_done), 32'd1);
        check_output("end_busy_keep", 32'(bus_keep.busy), 32'd0);
        check_output("end_ready_keep", 32'(bus_keep.load_ready), 32'd0);
        check_output("end_count_keep", 32'(bus_keep.load_count), 32'(n));
        check_output("end_error_keep", 32'(bus_keep.load_error), 32'(!has_last));
        check_output("end_count_clr", 32'(bus_clr.load_count), 32'(n));
        check_output("end_error_clr", 32'(bus_clr.load_error), 32'(!has_last));

        first_done = bus_clr.load_done ? 0 : -1;
        busy_cnt   = bus_clr.busy ? 1 : 0;

        // Fetch the last written word in the first RUN cycle of "keep".
        fetch_req  = 1'b1;
        fetch_addr = AW'(a);
        tick();
        fetch_req  = 1'b0;
        q_exp_keep = mem_keep[a];
        if (clear_len == 0) q_exp_clr = mem_clr[a];
        check_output("wr_rd_valid_keep", 32'(bus_keep.q_valid), 32'd1);
        check_output("wr_rd_q_keep", 32'(bus_keep.q), 32'(q_exp_keep));
        check_output("done_pulse_keep", 32'(bus_keep.load_done), 32'd0);
        check_output("wr_rd_valid_clr", 32'(bus_clr.q_valid), 32'(clear_len == 0));
        check_output("wr_rd_q_clr", 32'(bus_clr.q), 32'(q_exp_clr));

        kmax = (clear_len > 1) ? clear_len : 1;
        for (int k = 1; k <= kmax; k++) begin
            if (k > 1) tick();
            if (bus_clr.load_done && (first_done < 0)) first_done = k;
            if (bus_clr.busy) busy_cnt++;
        end
        check_output("clear_done_cycle_clr", 32'(first_done), 32'(clear_len));
        check_output("clear_busy_cycles_clr", 32'(busy_cnt), 32'(clear_len));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_clr[i]  = '0;
            mem_keep[i] = '0;
        end
        q_exp_clr  = '0;
        q_exp_keep = '0;

        // Reset for two cycles, then check idle outputs.
        reset = 1'b1;
        tick();
        tick();
        check_output("rst_q", 32'(bus_clr.q), 32'd0);
        check_output("rst_q_valid", 32'(bus_clr.q_valid), 32'd0);
        check_output("rst_busy", 32'(bus_clr.busy), 32'd0);
        check_output("rst_ready", 32'(bus_clr.load_ready), 32'd0);
        check_output("rst_count", 32'(bus_clr.load_count), 32'd0);
        check_output("rst_done", 32'(bus_clr.load_done), 32'd0);
        check_output("rst_error", 32'(bus_clr.load_error), 32'd0);
        check_output("rst_busy_keep", 32'(bus_keep.busy), 32'd0);
        reset = 1'b0;
        tick();
        do_fetch(3);
        tick();
        check_output("q_valid_pulse", 32'(bus_clr.q_valid), 32'd0);
        check_output("q_hold", 32'(bus_clr.q), 32'd0);

        // Preload so that address 10 holds BEEF.
        for (int i = 0; i < 11; i++) words[i] = DW'($urandom);
        words[10] = 16'hBEEF;
        apply_stimulus(11, 1'b1, 1'b0);
        do_fetch(10);

        // Short program: tail cleared on one instance, untouched on the other.
        words[0] = 16'h8000;
        words[1] = 16'h0006;
        words[2] = 16'h0001;
        words[3] = 16'h8800;
        apply_stimulus(4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_fetch(i);
        do_fetch(10);
        check_output("tail_cleared_clr", 32'(bus_clr.q), 32'h0000);
        check_output("tail_kept_keep", 32'(bus_keep.q), 32'hBEEF);

        // Random data with handshake gaps and fetches while busy.
        for (int r = 0; r < 2; r++) begin
            int n;
            n = int'($urandom_range(3, 9));
            for (int i = 0; i < n; i++) words[i] = DW'($urandom);
            apply_stimulus(n, 1'b1, 1'b1);
            for (int i = 0; i <= n; i++) do_fetch(i);
        end

        // Overflow: 32 words without last, then a 33rd that must be refused.
        for (int i = 0; i <= DEPTH; i++) words[i] = DW'($urandom);
        apply_stimulus(DEPTH, 1'b0, 1'b0);
        check_output("ovf_ready_33", 32'(bus_clr.load_ready), 32'd0);
        load_valid = 1'b1;
        load_data  = words[DEPTH];
        tick();
        load_valid = 1'b0;
        check_output("ovf_count_after_33", 32'(bus_clr.load_count), 32'd32);
        check_output("ovf_error_sticky", 32'(bus_clr.load_error), 32'd1);
        check_output("ovf_busy", 32'(bus_clr.busy), 32'd0);
        do_fetch(0);
        do_fetch(DEPTH - 1);

        for (int i = 0; i < 6; i++) do_fetch(int'($urandom_range(0, DEPTH - 1)));

        // Reset in the middle of a load after two of four words.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check_output("midrst_error_cleared", 32'(bus_clr.load_error), 32'd0);
        for (int i = 0; i < 2; i++) begin
            words[i]   = DW'($urandom);
            load_valid = 1'b1;
            load_data  = words[i];
            tick();
        end
        load_valid = 1'b0;
        mem_clr[0]  = words[0];
        mem_clr[1]  = words[1];
        mem_keep[0] = words[0];
        mem_keep[1] = words[1];
        check_output("midrst_count_before", 32'(bus_clr.load_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_exp_clr  = '0;
        q_exp_keep = '0;
        check_output("midrst_busy_clr", 32'(bus_clr.busy), 32'd0);
        check_output("midrst_busy_keep", 32'(bus_keep.busy), 32'd0);
        check_output("midrst_done_clr", 32'(bus_clr.load_done), 32'd0);
        check_output("midrst_ready_clr", 32'(bus_clr.load_ready), 32'd0);
        check_output("midrst_count_clr", 32'(bus_clr.load_count), 32'd0);
        tick();
        check_output("midrst_no_done_clr", 32'(bus_clr.load_done), 32'd0);
        check_output("midrst_no_done_keep", 32'(bus_keep.load_done), 32'd0);
        for (int i = 0; i < 4; i++) do_fetch(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
